// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use / RAW hazard detection.
// Ports: clk, rst (async active-low); flush; id_* decoded inputs; mem_dest /
// mem_wb_en from MEM; hazard_stall (comb); ex_* registered outputs;
// bubble_count (saturating stall-bubble count).
// Build option: define ID_EX_FORWARDING_EN for the forwarding variant
// (only load-use against EX stalls); undefined stalls on any EX/MEM RAW.
module id_ex_stage_reg #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int EXE_CMD_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [WORD_LEN-1:0]     id_pc,
    input  logic [WORD_LEN-1:0]     id_reg1,
    input  logic [WORD_LEN-1:0]     id_reg2,
    input  logic [WORD_LEN-1:0]     id_imm,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_src2_used,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r_en,
    input  logic                    id_mem_w_en,
    input  logic                    id_is_imm,
    input  logic [EXE_CMD_LEN-1:0]  id_exe_cmd,
    input  logic [REG_ADDR_LEN-1:0] mem_dest,
    input  logic                    mem_wb_en,
    output logic                    hazard_stall,
    output logic                    ex_valid,
    output logic                    ex_wb_en,
    output logic                    ex_mem_r_en,
    output logic                    ex_mem_w_en,
    output logic                    ex_is_imm,
    output logic [EXE_CMD_LEN-1:0]  ex_exe_cmd,
    output logic [WORD_LEN-1:0]     ex_pc,
    output logic [WORD_LEN-1:0]     ex_reg1,
    output logic [WORD_LEN-1:0]     ex_reg2,
    output logic [WORD_LEN-1:0]     ex_imm,
    output logic [REG_ADDR_LEN-1:0] ex_src1,
    output logic [REG_ADDR_LEN-1:0] ex_src2,
    output logic [REG_ADDR_LEN-1:0] ex_dest,
    output logic [15:0]             bubble_count
);

    typedef struct packed {
        logic                    valid;
        logic                    wb_en;
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic                    is_imm;
        logic [EXE_CMD_LEN-1:0]  exe_cmd;
        logic [WORD_LEN-1:0]     pc;
        logic [WORD_LEN-1:0]     reg1;
        logic [WORD_LEN-1:0]     reg2;
        logic [WORD_LEN-1:0]     imm;
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [REG_ADDR_LEN-1:0] dest;
    } id_ex_t;

    id_ex_t      ex_q, ex_d;
    logic [15:0] cnt_q, cnt_d;

    // r0 is hardwired zero, so it can never carry a dependency.
    logic raw_ex;
    assign raw_ex =
        ((id_src1 != '0) && (id_src1 == ex_q.dest)) ||
        (id_src2_used && (id_src2 != '0) &&
         (id_src2 == ex_q.dest));

`ifdef ID_EX_FORWARDING_EN
    // ALU results forward from EX/MEM; only a load in EX is too late.
    logic unused_mem;
    assign unused_mem = ^{mem_dest, mem_wb_en};

    assign hazard_stall = id_valid && ex_q.valid &&
                          ex_q.mem_r_en && raw_ex;
`else
    logic raw_mem;
    assign raw_mem =
        ((id_src1 != '0) && (id_src1 == mem_dest)) ||
        (id_src2_used && (id_src2 != '0) &&
         (id_src2 == mem_dest));

    // WB needs no check: the regfile writes on the falling edge.
    assign hazard_stall = id_valid &&
        ((ex_q.valid && ex_q.wb_en && raw_ex) ||
         (mem_wb_en && raw_mem));
`endif

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush || hazard_stall) begin
            // Bubble: kill side effects, data fields hold.
            ex_d.valid    = 1'b0;
            ex_d.wb_en    = 1'b0;
            ex_d.mem_r_en = 1'b0;
            ex_d.mem_w_en = 1'b0;
            // A flush overrides a simultaneous stall and is not counted.
            if (!flush && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            ex_d.valid    = id_valid;
            ex_d.wb_en    = id_wb_en;
            ex_d.mem_r_en = id_mem_r_en;
            ex_d.mem_w_en = id_mem_w_en;
            ex_d.is_imm   = id_is_imm;
            ex_d.exe_cmd  = id_exe_cmd;
            ex_d.pc       = id_pc;
            ex_d.reg1     = id_reg1;
            ex_d.reg2     = id_reg2;
            ex_d.imm      = id_imm;
            ex_d.src1     = id_src1;
            ex_d.src2     = id_src2;
            ex_d.dest     = id_dest;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_wb_en     = ex_q.wb_en;
    assign ex_mem_r_en  = ex_q.mem_r_en;
    assign ex_mem_w_en  = ex_q.mem_w_en;
    assign ex_is_imm    = ex_q.is_imm;
    assign ex_exe_cmd   = ex_q.exe_cmd;
    assign ex_pc        = ex_q.pc;
    assign ex_reg1      = ex_q.reg1;
    assign ex_reg2      = ex_q.reg2;
    assign ex_imm       = ex_q.imm;
    assign ex_src1      = ex_q.src1;
    assign ex_src2      = ex_q.src2;
    assign ex_dest      = ex_q.dest;
    assign bubble_count = cnt_q;

endmodule
